// File: rtl/div_seq.sv
// Restoring RV32M divider that borrows the core ALU; fixed latency 2*Width+4 cycles start-to-done.
// Backpressure: start is ignored while busy, abort flushes to IDLE without a done.
module div_seq #(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       op,
    input  logic [Width-1:0] dividend,
    input  logic [Width-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [Width-1:0] result,
    output logic [Width-1:0] alu_a,
    output logic [Width-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [Width-1:0] alu_c
);

    localparam int CW = (Width > 2) ? $clog2(Width) : 1;
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b0011;

    typedef enum logic [2:0] {
        S_IDLE, S_ABS_A, S_ABS_B, S_CMP, S_SUB, S_FIX, S_DONE
    } state_t;

    state_t            r_state, w_next;
    logic [Width-1:0]  r_q, r_r, r_b, r_result;
    logic [CW-1:0]     r_cnt;
    logic              r_rem, r_neg_a, r_neg_b, r_dz, r_take;
    logic [Width-1:0]  w_rp, w_sel;
    logic              w_neg;

    // Remainder shifted left with the next dividend bit; r_r[MSB] is the lost carry.
    assign w_rp  = {r_r[Width-2:0], r_q[Width-1]};
    assign w_sel = r_rem ? r_r : r_q;
    assign w_neg = r_rem ? r_neg_a : ((r_neg_a ^ r_neg_b) & ~r_dz);

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        alu_a  = '0;
        alu_b  = '0;
        alu_op = OP_ADD;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_ABS_A;
            end
            S_ABS_A: begin
                alu_b  = r_q;
                alu_op = OP_SUB;
                w_next = S_ABS_B;
            end
            S_ABS_B: begin
                alu_b  = r_b;
                alu_op = OP_SUB;
                w_next = S_CMP;
            end
            S_CMP: begin
                alu_a  = w_rp;
                alu_b  = r_b;
                alu_op = OP_CMP;
                w_next = S_SUB;
            end
            S_SUB: begin
                alu_a  = w_rp;
                alu_b  = r_b;
                alu_op = OP_SUB;
                w_next = (r_cnt == '0) ? S_FIX : S_CMP;
            end
            S_FIX: begin
                alu_b  = w_sel;
                alu_op = OP_SUB;
                w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (abort) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q      <= '0;
            r_r      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_rem    <= 1'b0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_dz     <= 1'b0;
            r_take   <= 1'b0;
        end else if (!abort) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rem   <= op[1];
                        r_q     <= dividend;
                        r_b     <= divisor;
                        r_r     <= '0;
                        r_neg_a <= ~op[0] & dividend[Width-1];
                        r_neg_b <= ~op[0] & divisor[Width-1];
                        r_dz    <= (divisor == '0);
                        r_cnt   <= CW'(Width - 1);
                    end
                end
                S_ABS_A: if (r_neg_a) r_q <= alu_c;
                S_ABS_B: if (r_neg_b) r_b <= alu_c;
                S_CMP:   r_take <= r_r[Width-1] | alu_c[0];
                S_SUB: begin
                    r_r   <= r_take ? alu_c : w_rp;
                    r_q   <= {r_q[Width-2:0], r_take};
                    r_cnt <= r_cnt - 1'b1;
                end
                S_FIX:   r_result <= w_neg ? alu_c : w_sel;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed and random checks of div_seq against a scoreboard of reference quotients/remainders.
module tb_div_seq;

    localparam int W = 32;
    localparam int LAT = 2 * W + 3;   // posedges after the accepting edge until done is seen

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  dividend = '0;
    logic [W-1:0]  divisor = '0;
    logic          busy, done;
    logic [W-1:0]  result, alu_a, alu_b, alu_c;
    logic [3:0]    alu_op;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] sb[$];

    always #5 clk = ~clk;

    div_seq #(.Width(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .op(op),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .result(result), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c)
    );

    always_comb begin
        alu_c = '0;
        case (alu_op)
            4'b0000: alu_c = alu_a + alu_b;
            4'b1000: alu_c = alu_a - alu_b;
            4'b0011: alu_c = {{(W-1){1'b0}}, (alu_a >= alu_b)};
            default: alu_c = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_model(input logic [1:0] o, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic signed [W-1:0] sa, sbv;
        sa = a;
        sbv = b;
        if (b == '0) return o[1] ? a : '1;
        if (!o[0] && a == {1'b1, {(W-1){1'b0}}} && b == '1)
            return o[1] ? '0 : {1'b1, {(W-1){1'b0}}};
        case (o)
            2'b00:   return sa / sbv;
            2'b01:   return a / b;
            2'b10:   return sa % sbv;
            default: return a % b;
        endcase
    endfunction

    // Launch one op, push its expectation, and check timing and result when done appears.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input bit mid_start);
        int lat;
        bit seen, busy_ok;
        @(negedge clk);
        start = 1'b1; op = o; dividend = a; divisor = b;
        sb.push_back(exp);
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0; seen = 0; busy_ok = 1;
        while (!seen && lat < 200) begin
            @(posedge clk);
            #1 lat++;
            if (mid_start && lat == 10) begin
                start = 1'b1; op = ~o; dividend = ~a; divisor = 32'd3;
            end else begin
                start = 1'b0;
            end
            if (done) seen = 1;
            else if (!busy) busy_ok = 0;
        end
        start = 1'b0;
        chk("done_seen", {31'b0, seen}, 32'd1);
        chk("latency", lat, LAT);
        chk("busy_during_op", {31'b0, busy_ok}, 32'd1);
        if (sb.size() > 0) chk("result", result, sb.pop_front());
        else chk("scoreboard_empty", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        chk("done_one_cycle", {31'b0, done}, 32'd0);
        chk("busy_fall", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        logic [W-1:0] prior, a, b;
        logic [1:0]   o;
        int           cnt;
        bit           spurious;

        #2;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_op", {28'b0, alu_op}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(2'b01, 32'd100, 32'd7, 32'd14, 0);
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 0);
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 0);
        run_op(2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 0);
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
        run_op(2'b01, 32'd1000, 32'd10, 32'd100, 1);

        // Abort at cycle 20: busy drops next cycle, result keeps its prior value.
        prior = result;
        @(negedge clk);
        start = 1'b1; op = 2'b01; dividend = 32'd999; divisor = 32'd4;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i < 20; i++) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        spurious = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1 if (done) spurious = 1;
        end
        chk("abort_no_done", {31'b0, spurious}, 32'd0);
        chk("abort_result", result, prior);

        // Abort together with start in IDLE drops the start.
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        chk("abort_wins_busy", {31'b0, busy}, 32'd0);

        run_op(2'b00, 32'd50, 32'hFFFF_FFFB, 32'hFFFF_FFF6, 0);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        start = 1'b1; op = 2'b00; dividend = 32'd77; divisor = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i < 30; i++) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_done", {31'b0, done}, 32'd0);
        chk("arst_result", result, 32'd0);
        chk("arst_alu_a", alu_a, 32'd0);
        chk("arst_alu_b", alu_b, 32'd0);
        chk("arst_alu_op", {28'b0, alu_op}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1 if (done || busy) spurious = 1;
        end
        chk("arst_no_done", {31'b0, spurious}, 32'd0);

        for (int n = 0; n < 400; n++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            cnt = $urandom_range(0, 7);
            if (cnt == 0) b = '0;
            else if (cnt == 1) b = 32'($urandom_range(1, 15));
            else if (cnt == 2) b = '1;
            else if (cnt == 3) a = 32'h8000_0000;
            else if (cnt == 4) b = {1'b1, 31'($urandom_range(0, 7))};
            run_op(o, a, b, ref_model(o, a, b), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
